rf_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 32x64 integer register file. It merges two write-back requesters into the file's single write port:
- port A: the in-order execute pipe;
- port B: the long-latency load/mul-div unit.

Arbitration uses valid/ready handshakes, priority to A, and a starvation limit that protects B. An optional 32-entry scoreboard tracks long-latency destinations in flight and raises a decode stall on read-after-write hazards. The block sits between the execute/memory stages and the register file write port.

---
 rtl/rf_wb_arbiter_if.sv | 28 ++
 rtl/rf_wb_arbiter.sv | 100 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus bundle: execute-pipe request (A), long-latency request (B) and registered register-file write port.
interface rf_wb_arbiter_if;
  logic        i_a_valid;
  logic        o_a_ready;
  logic [4:0]  i_a_addr;
  logic [63:0] i_a_wdata;
  logic        i_b_valid;
  logic        o_b_ready;
  logic [4:0]  i_b_addr;
  logic [63:0] i_b_wdata;
  logic        o_wen;
  logic [4:0]  o_waddr;
  logic [63:0] o_wdata;

  modport slave (
    input  i_a_valid, i_a_addr, i_a_wdata,
    input  i_b_valid, i_b_addr, i_b_wdata,
    output o_a_ready, o_b_ready,
    output o_wen, o_waddr, o_wdata
  );

  modport master (
    output i_a_valid, i_a_addr, i_a_wdata,
    output i_b_valid, i_b_addr, i_b_wdata,
    input  o_a_ready, o_b_ready,
    input  o_wen, o_waddr, o_wdata
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter (A priority, B forced after STARVE_MAX waits), ready is combinational, write stage is 1 cycle.
// Optional scoreboard/decode stall under RF_SCOREBOARD_EN; otherwise o_busy=0 and o_stall=0.
module rf_wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  rf_wb_arbiter_if.slave bus,
  input  logic        i_issue_valid,
  input  logic [4:0]  i_issue_rd,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic [31:0] o_busy,
  output logic        o_stall
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] r_starve_cnt;
  logic          w_force_b;
  logic          w_grant_a;
  logic          w_grant_b;
  logic          r_wen;
  logic [4:0]    r_waddr;
  logic [63:0]   r_wdata;

  assign w_force_b = (r_starve_cnt == CW'(STARVE_MAX));
  assign w_grant_a = bus.i_a_valid & ~(bus.i_b_valid & w_force_b);
  assign w_grant_b = bus.i_b_valid & (~bus.i_a_valid | w_force_b);

  // Readies are masked during reset so nothing is consumed while the write stage is held clear.
  assign bus.o_a_ready = w_grant_a & ~rst;
  assign bus.o_b_ready = w_grant_b & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (bus.i_b_valid && !w_grant_b) begin
      if (!w_force_b) r_starve_cnt <= r_starve_cnt + 1'b1;
    end else begin
      r_starve_cnt <= '0;
    end
  end

  // Writes to x0 are consumed but never reach the file; address/data then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= 1'b0;
      if (w_grant_a && bus.i_a_addr != 5'd0) begin
        r_wen   <= 1'b1;
        r_waddr <= bus.i_a_addr;
        r_wdata <= bus.i_a_wdata;
      end else if (w_grant_b && bus.i_b_addr != 5'd0) begin
        r_wen   <= 1'b1;
        r_waddr <= bus.i_b_addr;
        r_wdata <= bus.i_b_wdata;
      end
    end
  end

  assign bus.o_wen   = r_wen;
  assign bus.o_waddr = r_waddr;
  assign bus.o_wdata = r_wdata;

`ifdef RF_SCOREBOARD_EN
  logic [31:0] r_busy;
  logic [31:0] w_set;
  logic [31:0] w_clr;
  logic        w_hit1;
  logic        w_hit2;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_issue_valid && i_issue_rd != 5'd0) w_set[i_issue_rd] = 1'b1;
    if (r_wen) w_clr[r_waddr] = 1'b1;
  end

  // Set is OR-ed after the clear so a re-issue in the write cycle keeps the entry pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= ((r_busy & ~w_clr) | w_set) & 32'hFFFF_FFFE;
  end

  assign w_hit1  = r_wen && (r_waddr == i_rs1_addr);
  assign w_hit2  = r_wen && (r_waddr == i_rs2_addr);
  assign o_busy  = r_busy;
  assign o_stall = (r_busy[i_rs1_addr] & ~w_hit1) | (r_busy[i_rs2_addr] & ~w_hit2);
`else
  logic w_unused_sb;
  assign w_unused_sb = ^{i_issue_valid, i_issue_rd, i_rs1_addr, i_rs2_addr};
  assign o_busy  = 32'b0;
  assign o_stall = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration pattern, write stage, scoreboard and async reset.
module tb_rf_wb_arbiter;
`ifdef RF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] busy;
  logic        stall;
  int          n_assert;
  int          n_fail;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .i_issue_valid (issue_valid),
    .i_issue_rd    (issue_rd),
    .i_rs1_addr    (rs1_addr),
    .i_rs2_addr    (rs2_addr),
    .o_busy        (busy),
    .o_stall       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] pat;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.i_a_valid = 1'b1;
    bus.i_a_addr  = 5'd4;
    bus.i_a_wdata = 64'h44;
    bus.i_b_valid = 1'b0;
    bus.i_b_addr  = 5'd0;
    bus.i_b_wdata = 64'h0;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    rs1_addr    = 5'd0;
    rs2_addr    = 5'd0;

    // Reset state, with A valid to show ready is masked.
    @(posedge clk);
    #2;
    chk("rst_wen",    {63'd0, bus.o_wen}, 64'd0);
    chk("rst_waddr",  {59'd0, bus.o_waddr}, 64'd0);
    chk("rst_wdata",  bus.o_wdata, 64'd0);
    chk("rst_busy",   {32'd0, busy}, 64'd0);
    chk("rst_stall",  {63'd0, stall}, 64'd0);
    chk("rst_aready", {63'd0, bus.o_a_ready}, 64'd0);
    bus.i_a_valid = 1'b0;
    rst = 1'b0;

    // Only A valid.
    cyc();
    bus.i_a_valid = 1'b1;
    bus.i_a_addr  = 5'd5;
    bus.i_a_wdata = 64'h11;
    #1;
    chk("a_only_ready",  {63'd0, bus.o_a_ready}, 64'd1);
    chk("a_only_bready", {63'd0, bus.o_b_ready}, 64'd0);
    cyc();
    bus.i_a_valid = 1'b0;
    #1;
    chk("a_only_wen",   {63'd0, bus.o_wen}, 64'd1);
    chk("a_only_waddr", {59'd0, bus.o_waddr}, 64'd5);
    chk("a_only_wdata", bus.o_wdata, 64'h11);
    cyc();
    #1;
    chk("idle_wen",        {63'd0, bus.o_wen}, 64'd0);
    chk("idle_waddr_hold", {59'd0, bus.o_waddr}, 64'd5);
    chk("idle_wdata_hold", bus.o_wdata, 64'h11);

    // A and B both valid: AAAAB AAAAB.
    pat = 10'b10000_10000;
    bus.i_a_valid = 1'b1;
    bus.i_a_addr  = 5'd1;
    bus.i_a_wdata = 64'hAA;
    bus.i_b_valid = 1'b1;
    bus.i_b_addr  = 5'd2;
    bus.i_b_wdata = 64'hBB;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("starve_bready_%0d", i), {63'd0, bus.o_b_ready}, {63'd0, pat[i]});
      chk($sformatf("starve_aready_%0d", i), {63'd0, bus.o_a_ready}, {63'd0, ~pat[i]});
      cyc();
      #1;
      chk($sformatf("starve_waddr_%0d", i), {59'd0, bus.o_waddr}, pat[i] ? 64'd2 : 64'd1);
    end
    bus.i_a_valid = 1'b0;
    bus.i_b_valid = 1'b0;

    // B write to x0: consumed, no write.
    cyc();
    bus.i_b_valid = 1'b1;
    bus.i_b_addr  = 5'd0;
    bus.i_b_wdata = 64'hDEAD;
    #1;
    chk("x0_bready", {63'd0, bus.o_b_ready}, 64'd1);
    cyc();
    bus.i_b_valid = 1'b0;
    #1;
    chk("x0_wen",   {63'd0, bus.o_wen}, 64'd0);
    chk("x0_waddr", {59'd0, bus.o_waddr}, 64'd2);
    chk("x0_busy",  {32'd0, busy}, 64'd0);

    // Issue rd=7; rs1=7 stalls until B writes x7.
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    rs1_addr    = 5'd7;
    #1;
    chk("sb7_stall_pre", {63'd0, stall}, 64'd0);
    cyc();
    issue_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sb7_stall_%0d", i), {63'd0, stall}, {63'd0, SB});
      chk($sformatf("sb7_busy_%0d", i), {32'd0, busy}, SB ? 64'h80 : 64'd0);
      cyc();
      #1;
    end
    bus.i_b_valid = 1'b1;
    bus.i_b_addr  = 5'd7;
    bus.i_b_wdata = 64'h77;
    #1;
    chk("sb7_bready",      {63'd0, bus.o_b_ready}, 64'd1);
    chk("sb7_stall_accpt", {63'd0, stall}, {63'd0, SB});
    cyc();
    bus.i_b_valid = 1'b0;
    #1;
    chk("sb7_wen",        {63'd0, bus.o_wen}, 64'd1);
    chk("sb7_waddr",      {59'd0, bus.o_waddr}, 64'd7);
    chk("sb7_wdata",      bus.o_wdata, 64'h77);
    chk("sb7_stall_byp",  {63'd0, stall}, 64'd0);
    chk("sb7_busy_wcyc",  {32'd0, busy}, SB ? 64'h80 : 64'd0);
    cyc();
    #1;
    chk("sb7_busy_after",  {32'd0, busy}, 64'd0);
    chk("sb7_stall_after", {63'd0, stall}, 64'd0);

    // Re-issue rd=9 in the cycle x9 is written: set wins.
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    rs2_addr    = 5'd9;
    cyc();
    issue_valid = 1'b0;
    #1;
    chk("sb9_busy_set", {32'd0, busy}, SB ? 64'h200 : 64'd0);
    bus.i_b_valid = 1'b1;
    bus.i_b_addr  = 5'd9;
    bus.i_b_wdata = 64'h99;
    #1;
    chk("sb9_stall", {63'd0, stall}, {63'd0, SB});
    cyc();
    bus.i_b_valid = 1'b0;
    issue_valid   = 1'b1;
    #1;
    chk("sb9_wen",       {63'd0, bus.o_wen}, 64'd1);
    chk("sb9_waddr",     {59'd0, bus.o_waddr}, 64'd9);
    chk("sb9_stall_byp", {63'd0, stall}, 64'd0);
    cyc();
    issue_valid = 1'b0;
    #1;
    chk("sb9_set_wins", {32'd0, busy}, SB ? 64'h200 : 64'd0);

    // Clear x9 through A, then build o_wen=1 with busy=0x80 for the reset check.
    bus.i_a_valid = 1'b1;
    bus.i_a_addr  = 5'd9;
    bus.i_a_wdata = 64'h9A;
    cyc();
    bus.i_a_valid = 1'b0;
    cyc();
    #1;
    chk("sb9_cleared", {32'd0, busy}, 64'd0);
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    cyc();
    issue_valid   = 1'b0;
    bus.i_a_valid = 1'b1;
    bus.i_a_addr  = 5'd3;
    bus.i_a_wdata = 64'h33;
    cyc();
    #1;
    chk("pre_rst_wen",   {63'd0, bus.o_wen}, 64'd1);
    chk("pre_rst_waddr", {59'd0, bus.o_waddr}, 64'd3);
    chk("pre_rst_busy",  {32'd0, busy}, SB ? 64'h80 : 64'd0);
    chk("pre_rst_stall", {63'd0, stall}, {63'd0, SB});
    #1;
    rst = 1'b1;
    #1;
    chk("arst_wen",    {63'd0, bus.o_wen}, 64'd0);
    chk("arst_waddr",  {59'd0, bus.o_waddr}, 64'd0);
    chk("arst_wdata",  bus.o_wdata, 64'd0);
    chk("arst_busy",   {32'd0, busy}, 64'd0);
    chk("arst_stall",  {63'd0, stall}, 64'd0);
    chk("arst_aready", {63'd0, bus.o_a_ready}, 64'd0);
    bus.i_a_valid = 1'b0;
    #2;
    rst = 1'b0;
    cyc();
    #1;
    chk("post_rst_wen", {63'd0, bus.o_wen}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
